// File: rtl/mont_precompute.sv
// Montgomery domain constants: R mod n and R^2 mod n (R = 2^WIDTH), built by
// 2*WIDTH modular doublings of an accumulator that starts at 1 mod n.
module mont_precompute #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] rmodn,
  output logic [WIDTH-1:0] r2modn,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken only in IDLE; done pulses for one cycle and
  // rmodn/r2modn/err are stable from done until the next accepted start.
  localparam int CW = $clog2(2 * WIDTH) + 1;
  localparam logic [CW-1:0] CNT_R  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_R2 = CW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] rmodn_q, rmodn_d;
  logic [WIDTH-1:0] r2modn_q, r2modn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   dbl;
  logic [WIDTH-1:0] dbl_sub;
  logic [WIDTH-1:0] dx;
  logic             dbl_ge;
  logic             n_bad;

  // Modular doubling: x < n_q, so a single conditional subtract keeps 2x < 2n_q
  // inside [0, n_q); the low WIDTH bits of the wrapped subtract are exact.
  always_comb begin
    dbl     = {x_q, 1'b0};
    dbl_ge  = (dbl >= {1'b0, n_q});
    dbl_sub = dbl[WIDTH-1:0] - n_q;
    dx      = dbl_ge ? dbl_sub : dbl[WIDTH-1:0];
    n_bad   = ~n_q[0];
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (n_bad || (cnt_q == CNT_R2)) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == FIN);
    state_dbg = state_q;
  end

  always_comb begin
    n_d      = n_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rmodn_d  = rmodn_q;
    r2modn_d = r2modn_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d   = n;
          // For n == 1 every residue is 0, so the seed itself must be 0.
          x_d   = (n == WIDTH'(1)) ? '0 : WIDTH'(1);
          cnt_d = '0;
          err_d = 1'b0;
        end
      end
      RUN: begin
        if (n_bad) begin
          err_d    = 1'b1;
          rmodn_d  = '0;
          r2modn_d = '0;
        end else begin
          x_d   = dx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_R)  rmodn_d  = dx;
          if (cnt_q == CNT_R2) r2modn_d = dx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      n_q      <= '0;
      x_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rmodn_q  <= '0;
      r2modn_q <= '0;
    end else begin
      n_q      <= n_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rmodn_q  <= rmodn_d;
      r2modn_q <= r2modn_d;
    end
  end

  assign rmodn  = rmodn_q;
  assign r2modn = r2modn_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mont_precompute.sv
// Bench for mont_precompute: random and directed moduli checked against
// R mod n and R^2 mod n computed with wide integer modulo.
module tb_mont_precompute;

  localparam int W   = 1024;
  localparam int LAT = 2 * W;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] n = '0;
  logic [W-1:0] rmodn, r2modn;
  logic         busy, done, err;
  logic [1:0]   state_dbg;

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;

  logic [W-1:0] exp_rm_q[$];
  logic [W-1:0] exp_r2_q[$];
  logic         exp_err_q[$];
  int           exp_cyc_q[$];

  mont_precompute #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .n(n),
    .rmodn(rmodn), .r2modn(r2modn), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1);
  end

  // reference model
  function automatic void model(input logic [W-1:0] nv, output logic [W-1:0] rm,
                               output logic [W-1:0] r2, output logic e);
    logic [2*W:0] big;
    logic [2*W:0] nn;
    if (nv == '0 || nv[0] == 1'b0) begin
      rm = '0; r2 = '0; e = 1'b1;
    end else begin
      nn = '0;
      nn[W-1:0] = nv;
      big = '0; big[W] = 1'b1;
      big = big % nn;
      rm = big[W-1:0];
      big = '0; big[2*W] = 1'b1;
      big = big % nn;
      r2 = big[W-1:0];
      e = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] rand_odd();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    v[0] = 1'b1;
    return v;
  endfunction

  task automatic chk_vec(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    n_vec++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL %s: got low128 %h want low128 %h", nm, a[127:0], e[127:0]);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_mis++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // scoreboard
  task automatic push(input logic [W-1:0] nv, input int base);
    logic [W-1:0] rm, r2;
    logic e;
    model(nv, rm, r2, e);
    exp_rm_q.push_back(rm);
    exp_r2_q.push_back(r2);
    exp_err_q.push_back(e);
    exp_cyc_q.push_back(base + 1 + (e ? 1 : LAT));
  endtask

  task automatic flush();
    exp_rm_q.delete();
    exp_r2_q.delete();
    exp_err_q.delete();
    exp_cyc_q.delete();
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_rm_q.size() == 0) begin
        chk_int("unexpected_done", int'(done), 0);
      end else begin
        chk_vec("rmodn", rmodn, exp_rm_q.pop_front());
        chk_vec("r2modn", r2modn, exp_r2_q.pop_front());
        chk_int("err", int'(err), int'(exp_err_q.pop_front()));
        chk_int("done_cycle", cyc, exp_cyc_q.pop_front());
        chk_int("busy_at_done", int'(busy), 0);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] nv);
    @(negedge clk);
    n = nv;
    start = 1'b1;
    push(nv, cyc);
    @(negedge clk);
    start = 1'b0;
    n = ~nv;
    chk_int("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_rm_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_rm_q.size() != 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL done_timeout: %0d results outstanding after %0d cycles", exp_rm_q.size(), budget);
      flush();
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk_vec({tag, "_rmodn"}, rmodn, '0);
    chk_vec({tag, "_r2modn"}, r2modn, '0);
    chk_int({tag, "_err"}, int'(err), 0);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    logic [W-1:0] v, v2;

    repeat (3) @(negedge clk);
    chk_cleared("reset");
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    // directed moduli
    issue(W'(11)); wait_drain(LAT + 20);
    chk_vec("golden_rmodn_11", rmodn, W'(5));
    chk_vec("golden_r2modn_11", r2modn, W'(3));
    issue(W'(7)); wait_drain(LAT + 20);
    chk_vec("golden_rmodn_7", rmodn, W'(2));
    chk_vec("golden_r2modn_7", r2modn, W'(4));
    v = '0; v[W-1] = 1'b1; v[0] = 1'b1;
    issue(v); wait_drain(LAT + 20);
    v2 = '0; v2[W-1] = 1'b1; v2 = v2 - W'(1);
    chk_vec("golden_rmodn_2p1023p1", rmodn, v2);
    issue(W'(10)); wait_drain(20);
    issue('0); wait_drain(20);
    issue(W'(1)); wait_drain(LAT + 20);
    chk_int("n1_err", int'(err), 0);

    // random odd moduli, some small
    for (int i = 0; i < 5; i++) begin
      v = rand_odd();
      if (i == 4) v = W'($urandom_range(3, 65535) | 1);
      issue(v); wait_drain(LAT + 20);
    end

    // start during RUN is ignored
    v = rand_odd();
    issue(v);
    repeat (500) @(negedge clk);
    start = 1'b1; n = rand_odd();
    @(negedge clk);
    start = 1'b0;
    wait_drain(LAT + 50);

    // reset mid-run aborts without a done pulse
    issue(rand_odd());
    repeat (1000) @(negedge clk);
    flush();
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    chk_cleared("abort");
    repeat (LAT + 20) @(negedge clk);
    issue(rand_odd()); wait_drain(LAT + 20);

    // start held high: back-to-back runs with an IDLE gap
    v = rand_odd();
    @(negedge clk);
    n = v;
    start = 1'b1;
    push(v, cyc);
    push(v, cyc + LAT + 2);
    wait_drain(2 * LAT + 50);
    start = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mont_precompute.md
MONT_PRECOMPUTE -- requirements
Module: mont_precompute

Interface
REQ-001 The block SHALL be built on one clock; reset is synchronous and active-high. The clock port is clk and the reset port is resetn; resetn is asserted when high.
REQ-002 Parameter WIDTH SHALL default to 1024 and set the modulus width in bits (R = 2^WIDTH).
REQ-003 clk SHALL be an input, 1 bit: rising-edge clock.
REQ-004 resetn SHALL be an input, 1 bit: synchronous reset, active-high.
REQ-005 start SHALL be an input, 1 bit: one-cycle request to begin a precompute.
REQ-006 n SHALL be an input, WIDTH bits: modulus, sampled only on an accepted start.
REQ-007 rmodn SHALL be an output, WIDTH bits: R mod n, registered.
REQ-008 r2modn SHALL be an output, WIDTH bits: R^2 mod n, registered; it feeds montgomery_exp r2modn directly.
REQ-009 busy SHALL be an output, 1 bit: high while a computation is in progress.
REQ-010 done SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-011 err SHALL be an output, 1 bit: modulus invalid (n even or n == 0); valid while done is high and held until the next accepted start.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and FIN; RUN is the only state with busy = 1.
REQ-013 In IDLE, start = 1 at edge k SHALL latch n into n_q, set the accumulator x to 1 and the counter cnt to 0, clear err, and move to RUN.
REQ-014 If the latched n is even or zero, the FSM SHALL go directly from RUN to FIN at the next edge, set err = 1, and clear rmodn and r2modn to 0.
REQ-015 Each RUN edge SHALL compute x <= d(x), where d(x) = 2x - n_q if 2x >= n_q and 2x otherwise. The compare and subtract are WIDTH+1 bits wide, and one conditional subtract suffices because x < n_q always holds.
REQ-016 Each RUN edge SHALL increment cnt, which is log2(2*WIDTH)+1 bits wide.
REQ-017 At the RUN edge with cnt == WIDTH-1, rmodn SHALL load d(x).
REQ-018 At the RUN edge with cnt == 2*WIDTH-1, r2modn SHALL load d(x) and the FSM SHALL move to FIN.
REQ-019 Latency SHALL be 2*WIDTH RUN edges (2048 for WIDTH = 1024): done is high in the cycle after edge k+2*WIDTH.
REQ-020 In FIN, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE at the next edge.
REQ-021 start SHALL be ignored in RUN and FIN, with no restart and no queuing.
REQ-022 A start present in the same cycle as the FIN-to-IDLE transition SHALL be ignored; start is accepted only when the FSM is already in IDLE.
REQ-023 rmodn, r2modn and err SHALL hold their values from done until the next accepted start; rmodn remains stale during the first WIDTH RUN edges.
REQ-024 Changes on n after start is accepted SHALL have no effect on the computation.
REQ-025 For n == 1 the block SHALL produce rmodn = 0 and r2modn = 0 with err = 0.

Reset
REQ-026 resetn = 1 at any clock edge SHALL force IDLE and clear busy, done, err, rmodn, r2modn, x, cnt and n_q to 0.
REQ-027 resetn = 1 mid-RUN SHALL abort the computation with no done pulse; the first start after reset is released SHALL begin a fresh computation.
REQ-028 resetn SHALL take priority over start in the same cycle.

Verification
REQ-029 n = 11 (WIDTH 1024), start pulse -> done after 2048 cycles with rmodn = 5, r2modn = 3, err = 0.
REQ-030 n = 7 -> rmodn = 2, r2modn = 4; n = 2^1023+1 -> rmodn = 2^1023-1, r2modn = 4.
REQ-031 n = 1024'h8e7d05e5...9cf7f9f7 (montgomery_exp test vector 1) -> rmodn = 1024'h7182fa1a...63080609 and r2modn = 1024'h322c11e7...a6c76a (golden values). Chaining these outputs into montgomery_exp SHALL reproduce its expected result.
REQ-032 n = 10 -> done two cycles after start, err = 1, rmodn = r2modn = 0.
REQ-033 start repulsed at cycle 500 of a run -> no restart and done at cycle 2048; resetn pulse at cycle 1000 of a second run -> outputs 0 and no done pulse.
REQ-034 Back-to-back: start held high continuously -> each run has 2048-cycle latency, with at least one IDLE cycle between done and the next run start.
